// File: rtl/uart_im_loader_if.sv
// rtl/uart_im_loader_if.sv - byte stream in, instruction-memory write port out
interface uart_im_loader_if;
    logic        uart_v;
    logic [7:0]  uart_d;
    logic        im_we;
    logic [31:0] im_wa;
    logic [31:0] im_wd;

    modport master (output uart_v, output uart_d, input im_we, input im_wa, input im_wd);
    modport slave  (input uart_v, input uart_d, output im_we, output im_wa, output im_wd);
endinterface

// File: rtl/uart_im_loader.sv
// rtl/uart_im_loader.sv - framed UART program loader into instruction memory
module uart_im_loader #(
    parameter int MAX_WORDS   = 64,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    uart_im_loader_if.slave   bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);
    localparam int              CNT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);
    localparam logic [7:0]      MAX_N     = 8'(MAX_WORDS);
    localparam logic [7:0]      SYNC_BYTE = 8'hA5;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SYNC = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    logic [2:0]       state, state_nxt;
    logic [7:0]       len, word_idx, sum;
    logic [1:0]       byte_idx;
    logic [31:0]      shift;
    logic [CNT_W-1:0] idle_cnt;
    logic             we_q;
    logic [31:0]      wa_q, wd_q;

    logic        in_frame, timed_out, len_bad, word_last;
    logic [31:0] word_full;

    // Bytes arrive LSB first, so each new byte enters at the top of the word.
    assign in_frame  = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign timed_out = in_frame && !bus.uart_v && (idle_cnt == CNT_LIMIT);
    assign len_bad   = (bus.uart_d == 8'd0) || (bus.uart_d > MAX_N);
    assign word_full = {bus.uart_d, shift[31:8]};
    assign word_last = (byte_idx == 2'd3) && (word_idx == len - 8'd1);

    assign bus.im_we = we_q;
    assign bus.im_wa = wa_q;
    assign bus.im_wd = wd_q;

    // Next-state decode; a byte in the limit cycle takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: state_nxt = S_SYNC;
                S_SYNC: if (bus.uart_v && bus.uart_d == SYNC_BYTE) state_nxt = S_LEN;
                S_LEN, S_DATA, S_CSUM: begin
                    if (bus.uart_v) begin
                        case (state)
                            S_LEN:   state_nxt = len_bad ? S_ERR : S_DATA;
                            S_DATA:  if (word_last) state_nxt = S_CSUM;
                            default: state_nxt = (bus.uart_d == sum) ? S_DONE : S_ERR;
                        endcase
                    end else if (timed_out) begin
                        state_nxt = S_ERR;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Datapath, counters and registered outputs; enable low overrides any pending byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
            len      <= 8'd0;
            word_idx <= 8'd0;
            byte_idx <= 2'd0;
            sum      <= 8'd0;
            shift    <= 32'd0;
            idle_cnt <= '0;
            we_q     <= 1'b0;
            wa_q     <= 32'd0;
            wd_q     <= 32'd0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_LEN) || (state_nxt == S_DATA) || (state_nxt == S_CSUM);
            we_q  <= 1'b0;

            if (enable && in_frame && !bus.uart_v && !timed_out)
                idle_cnt <= idle_cnt + 1'b1;
            else
                idle_cnt <= '0;

            if (enable) begin
                if (state == S_IDLE) begin
                    done     <= 1'b0;
                    err      <= 1'b0;
                    err_code <= 2'd0;
                    word_idx <= 8'd0;
                    byte_idx <= 2'd0;
                    sum      <= 8'd0;
                end else if (in_frame && bus.uart_v) begin
                    case (state)
                        S_LEN: begin
                            if (len_bad) begin
                                err      <= 1'b1;
                                err_code <= 2'd1;
                            end else begin
                                len <= bus.uart_d;
                            end
                        end
                        S_DATA: begin
                            sum      <= sum + bus.uart_d;
                            shift    <= word_full;
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                we_q <= 1'b1;
                                wa_q <= {24'd0, word_idx};
                                wd_q <= word_full;
                                if (!word_last) word_idx <= word_idx + 8'd1;
                            end
                        end
                        default: begin
                            if (bus.uart_d == sum) begin
                                done <= 1'b1;
                            end else begin
                                err      <= 1'b1;
                                err_code <= 2'd3;
                            end
                        end
                    endcase
                end else if (timed_out) begin
                    err      <= 1'b1;
                    err_code <= 2'd2;
                end
            end
        end
    end
endmodule
